// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: ID/EX pipeline register with two-entry skid buffer, flush and saturating stall counter
module id_ex_skid_reg #(
  parameter int CTRL_W  = 12,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_rs_data,
  input  logic [31:0]        in_rt_data,
  input  logic [31:0]        in_imm_ext,
  input  logic [4:0]         in_rd_addr,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_rs_data,
  output logic [31:0]        out_rt_data,
  output logic [31:0]        out_imm_ext,
  output logic [4:0]         out_rd_addr,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);
  localparam int BW = 133 + CTRL_W;
  logic [BW-1:0] in_b, main_b, skid_b;
  logic main_valid, skid_valid, accept, emit, load_main;
  assign in_b = {in_pc, in_rs_data, in_rt_data, in_imm_ext, in_rd_addr, in_ctrl};
  assign {out_pc, out_rs_data, out_rt_data, out_imm_ext, out_rd_addr, out_ctrl} = main_b;
  assign in_ready = ~skid_valid;
  assign out_valid = main_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign accept = in_valid & in_ready;
  assign emit = main_valid & out_ready;
  assign load_main = ~main_valid | emit;
  always_ff @(posedge clk) begin
    if (rst) begin
      main_b <= '0;
      skid_b <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (load_main && (skid_valid || accept)) main_b <= skid_valid ? skid_b : in_b;
      if (main_valid && !emit && !skid_valid && accept) skid_b <= in_b;
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (load_main) main_valid <= skid_valid | accept;
        skid_valid <= main_valid & ~emit & (skid_valid | accept);
        if (main_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb_id_ex_skid_reg: randomized and directed checks of id_ex_skid_reg against a FIFO reference model
module tb_id_ex_skid_reg;
  localparam int CTRL_W = 12;
  localparam int STALL_W = 4;
  localparam int BW = 133 + CTRL_W;
  localparam int SMAX = 15;
  logic clk = 0;
  logic rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [BW-1:0] in_b = '0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_rs_data, out_rt_data, out_imm_ext;
  logic [4:0] out_rd_addr;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0] occupancy;
  logic [STALL_W-1:0] stall_cnt;
  logic [BW-1:0] q[$];
  int exp_cnt = 0, n_acc = 0, n_emit = 0, n_chk = 0, n_err = 0;
  bit acc;
  always #5 clk = ~clk;
  id_ex_skid_reg #(.CTRL_W(CTRL_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_b[144:113]), .in_rs_data(in_b[112:81]), .in_rt_data(in_b[80:49]),
    .in_imm_ext(in_b[48:17]), .in_rd_addr(in_b[16:12]), .in_ctrl(in_b[11:0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_imm_ext(out_imm_ext), .out_rd_addr(out_rd_addr),
    .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [BW-1:0] rnd(input logic [31:0] pc, input logic [31:0] imm);
    return {pc, $urandom, $urandom, imm, 5'($urandom), 12'($urandom)};
  endfunction
  task automatic update();
    bit a = in_valid && q.size() < 2;
    bit e = q.size() > 0 && out_ready;
    acc = 0;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else if (flush) begin
      if (e) n_emit++;
      q.delete();
      acc = a;
    end else begin
      if (q.size() > 0 && !out_ready && exp_cnt < SMAX) exp_cnt++;
      if (e) begin
        void'(q.pop_front());
        n_emit++;
      end
      if (a) begin
        q.push_back(in_b);
        n_acc++;
      end
      acc = a;
    end
  endtask
  task automatic cycle();
    chk("out_valid", 160'(out_valid), 160'(q.size() > 0));
    chk("in_ready", 160'(in_ready), 160'(q.size() < 2));
    chk("occupancy", 160'(occupancy), 160'(q.size()));
    chk("stall_cnt", 160'(stall_cnt), 160'(exp_cnt));
    if (q.size() > 0)
      chk("bundle", 160'({out_pc, out_rs_data, out_rt_data, out_imm_ext, out_rd_addr, out_ctrl}), 160'(q[0]));
    @(posedge clk);
    update();
    @(negedge clk);
  endtask
  task automatic send(input logic [BW-1:0] b);
    int n = 0;
    in_valid = 1;
    in_b = b;
    do begin
      cycle();
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("send_timeout", 160'(acc), 160'(1));
  endtask
  task automatic pulse_rst();
    rst = 1;
    in_valid = 0;
    cycle();
    rst = 0;
  endtask
  initial begin
    logic [31:0] imms [8] = '{32'h00007FFF, 32'hFFFF8000, 32'hFFFFFFFE, 32'h0, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    int guard;
    rst = 1;
    in_valid = 1;
    in_b = rnd(32'h1234, 32'h5678);
    repeat (2) @(posedge clk);
    update();
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_occupancy", 160'(occupancy), 160'(0));
    chk("rst_stall", 160'(stall_cnt), 160'(0));
    chk("rst_imm", 160'(out_imm_ext), 160'(0));
    out_ready = 1;
    for (int i = 0; i < 8; i++) send(rnd(32'(i * 4), imms[i]));
    in_valid = 0;
    repeat (2) cycle();
    chk("stream_stall", 160'(stall_cnt), 160'(0));
    pulse_rst();
    out_ready = 0;
    send(rnd(32'h100, 32'hFFFF8000));
    send(rnd(32'h104, 32'h00007FFF));
    in_b = rnd(32'h108, 32'h1);
    repeat (4) cycle();
    chk("bp_occupancy", 160'(occupancy), 160'(2));
    chk("bp_in_ready", 160'(in_ready), 160'(0));
    chk("bp_stall", 160'(stall_cnt), 160'(5));
    chk("bp_head_pc", 160'(out_pc), 160'(32'h100));
    out_ready = 1;
    send(in_b);
    in_valid = 0;
    repeat (3) cycle();
    out_ready = 0;
    send(rnd(32'h200, 32'h2));
    send(rnd(32'h204, 32'h3));
    chk("fl_pre_occ", 160'(occupancy), 160'(2));
    in_valid = 1;
    in_b = rnd(32'h208, 32'h4);
    flush = 1;
    cycle();
    flush = 0;
    in_valid = 0;
    chk("fl_out_valid", 160'(out_valid), 160'(0));
    chk("fl_occupancy", 160'(occupancy), 160'(0));
    chk("fl_in_ready", 160'(in_ready), 160'(1));
    chk("fl_stall", 160'(stall_cnt), 160'(6));
    out_ready = 1;
    repeat (3) cycle();
    out_ready = 0;
    send(rnd(32'h300, 32'h5));
    in_valid = 0;
    repeat (20) cycle();
    chk("sat_stall", 160'(stall_cnt), 160'(15));
    cycle();
    chk("sat_hold", 160'(stall_cnt), 160'(15));
    out_ready = 1;
    repeat (2) cycle();
    pulse_rst();
    n_acc = 0;
    n_emit = 0;
    in_b = rnd($urandom, $urandom);
    guard = 0;
    while (n_acc < 1000 && guard < 20000) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      cycle();
      if (acc) in_b = rnd($urandom, $urandom);
      guard++;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (4) cycle();
    chk("rand_accepted", 160'(n_acc), 160'(1000));
    chk("rand_emitted", 160'(n_emit), 160'(n_acc));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
